// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus bundle
// Purpose: groups the two writeback request channels, the registered
//          register-file write port and the decode hazard lookup.
// Ports (modport slave = arbiter side):
//   req0_valid/addr/data in, req0_ready out   requester 0 (EX/MEM result)
//   req1_valid/addr/data in, req1_ready out   requester 1 (multicycle result)
//   we/waddr/wdata out                         register file write port
//   raddr1/raddr2 in, hz1/hz2 out              decode read-address hazard flags
interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          hz1;
  logic          hz2;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output raddr1, raddr2,
    input  req0_ready, req1_ready,
    input  we, waddr, wdata,
    input  hz1, hz2
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  raddr1, raddr2,
    output req0_ready, req1_ready,
    output we, waddr, wdata,
    output hz1, hz2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter for the register file write port
// Purpose: one-entry holding buffer per requester, grants in acceptance
//          order, registered write port, combinational read hazard flags.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  regfile_wb_arbiter_if.slave (request channels, write port, hazards)
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  logic [1:0]    buf_v;
  logic [AW-1:0] buf_addr [2];
  logic [DW-1:0] buf_data [2];
  logic          old1;
  logic          rr;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];
  logic [1:0]    grant;
  logic          gsel;
  logic [1:0]    ready;
  logic [1:0]    load;

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_addr[0] = bus.req0_addr;
  assign req_addr[1] = bus.req1_addr;
  assign req_data[0] = bus.req0_data;
  assign req_data[1] = bus.req1_data;

  // The oldest valid entry always wins, so issue order equals acceptance order.
  always_comb begin
    grant = buf_v;
    if (buf_v == 2'b11) begin
      grant = old1 ? 2'b10 : 2'b01;
    end
  end

  assign gsel  = grant[1];
  assign ready = ~buf_v | grant;

  // Writes to register 0 are swallowed: accepted but never buffered.
  always_comb begin
    load = 2'b00;
    for (int n = 0; n < 2; n++) begin
      load[n] = req_valid[n] & ready[n] & (req_addr[n] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v   <= 2'b00;
      old1    <= 1'b0;
      rr      <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int n = 0; n < 2; n++) begin
        buf_addr[n] <= '0;
        buf_data[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (load[n]) begin
          buf_v[n]    <= 1'b1;
          buf_addr[n] <= req_addr[n];
          buf_data[n] <= req_data[n];
        end else if (grant[n]) begin
          buf_v[n] <= 1'b0;
        end
      end

      // Age tracking only matters when two entries coexist after the edge.
      if (load == 2'b11) begin
        old1 <= rr;
        rr   <= ~rr;
      end else if (load == 2'b10 && buf_v[0] && !grant[0]) begin
        old1 <= 1'b0;
      end else if (load == 2'b01 && buf_v[1] && !grant[1]) begin
        old1 <= 1'b1;
      end

      we_q <= |grant;
      if (|grant) begin
        waddr_q <= buf_addr[gsel];
        wdata_q <= buf_data[gsel];
      end
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;

  // Entries already in the output register are forwarded by the register
  // file, so only still-buffered writes count as hazards.
  assign bus.hz1 = (bus.raddr1 != '0) &
                   ((buf_v[0] & (buf_addr[0] == bus.raddr1)) |
                    (buf_v[1] & (buf_addr[1] == bus.raddr1)));
  assign bus.hz2 = (bus.raddr2 != '0) &
                   ((buf_v[0] & (buf_addr[0] == bus.raddr2)) |
                    (buf_v[1] & (buf_addr[1] == bus.raddr2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic       src;
    logic [4:0] addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending writes in acceptance order; head is issued next.
  ent_t        q[$];
  bit          m_rr;
  logic        e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  logic [3:0]  st_got, st_exp;
  logic [37:0] out_got, out_exp;
  logic [1:0]  m_acc;

  task automatic model_reset();
    q.delete();
    m_rr    = 1'b0;
    e_we    = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
  endtask

  // Drives one cycle, predicts status/outputs, samples the DUT (no comparing).
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit full0, full1, g0, g1, rdy0, rdy1, h1, h2, l0, l1;
    ent_t e0, e1;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.raddr1 = r1; bus.raddr2 = r2;
    full0 = 0; full1 = 0; h1 = 0; h2 = 0;
    foreach (q[i]) begin
      if (q[i].src) full1 = 1; else full0 = 1;
      if (r1 != 0 && q[i].addr == r1) h1 = 1;
      if (r2 != 0 && q[i].addr == r2) h2 = 1;
    end
    g0 = (q.size() > 0) && !q[0].src;
    g1 = (q.size() > 0) && q[0].src;
    rdy0 = !full0 || g0;
    rdy1 = !full1 || g1;
    st_exp = {rdy0, rdy1, h1, h2};
    if (q.size() > 0) begin
      e_we = 1'b1; e_waddr = q[0].addr; e_wdata = q[0].data;
      void'(q.pop_front());
    end else begin
      e_we = 1'b0;
    end
    out_exp = {e_we, e_waddr, e_wdata};
    m_acc = {v1 & rdy1, v0 & rdy0};
    l0 = v0 && rdy0 && (a0 != 0);
    l1 = v1 && rdy1 && (a1 != 0);
    e0 = {1'b0, a0, d0};
    e1 = {1'b1, a1, d1};
    if (l0 && l1) begin
      if (!m_rr) begin q.push_back(e0); q.push_back(e1); end
      else begin q.push_back(e1); q.push_back(e0); end
      m_rr = !m_rr;
    end else if (l0) begin
      q.push_back(e0);
    end else if (l1) begin
      q.push_back(e1);
    end
    #3;
    st_got = {bus.req0_ready, bus.req1_ready, bus.hz1, bus.hz2};
    @(posedge clk);
    #1;
    out_got = {bus.we, bus.waddr, bus.wdata};
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.raddr1 = 3; bus.raddr2 = 5;
    model_reset();
    #12;
    st_got  = {bus.req0_ready, bus.req1_ready, bus.hz1, bus.hz2};
    out_got = {bus.we, bus.waddr, bus.wdata};
    total++;
    if (st_got !== 4'b1100) begin bad++; $display("FAIL reset_status: got %b expected 1100", st_got); end
    total++;
    if (out_got !== 38'd0) begin bad++; $display("FAIL reset_out: got %h expected 0", out_got); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    step(1, 3, 32'h11111111, 0, 0, 0, 3, 0);
    total++;
    if (st_got !== st_exp || st_got[3] !== 1'b1) begin bad++; $display("FAIL single_accept: got %b expected %b", st_got, st_exp); end
    total++;
    if (out_got !== out_exp) begin bad++; $display("FAIL single_out0: got %h expected %h", out_got, out_exp); end
    idle(3, 0);
    total++;
    if (st_got !== st_exp || st_got[1] !== 1'b1) begin bad++; $display("FAIL single_hz: got %b expected %b", st_got, st_exp); end
    total++;
    if (out_got !== {1'b1, 5'd3, 32'h11111111}) begin bad++; $display("FAIL single_write: got %h expected %h", out_got, {1'b1, 5'd3, 32'h11111111}); end
    idle(3, 0);
    total++;
    if (st_got !== st_exp || st_got[1] !== 1'b0) begin bad++; $display("FAIL single_hz_clear: got %b expected %b", st_got, st_exp); end
    total++;
    if (out_got !== out_exp) begin bad++; $display("FAIL single_out2: got %h expected %h", out_got, out_exp); end
  endtask

  task automatic test_contention();
    logic [31:0] want [4];
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hB; want[3] = 32'hA;
    for (int p = 0; p < 2; p++) begin
      step(1, 5, 32'hA, 1, 5, 32'hB, 5, 0);
      total++;
      if (st_got !== st_exp) begin bad++; $display("FAIL contention_status: got %b expected %b", st_got, st_exp); end
      for (int k = 0; k < 2; k++) begin
        idle(5, 0);
        total++;
        if (out_got !== out_exp || out_got[37] !== 1'b1 || out_got[31:0] !== want[p*2+k])
          begin bad++; $display("FAIL contention_order: got %h expected %h", out_got, out_exp); end
      end
    end
  endtask

  task automatic test_age();
    step(0, 0, 0, 1, 7, 32'hC, 7, 0);
    total++;
    if (st_got !== st_exp) begin bad++; $display("FAIL age_accept1: got %b expected %b", st_got, st_exp); end
    step(1, 7, 32'hD, 0, 0, 0, 7, 0);
    total++;
    if (st_got !== st_exp || st_got[3] !== 1'b1) begin bad++; $display("FAIL age_ready0: got %b expected %b", st_got, st_exp); end
    total++;
    if (out_got !== out_exp || out_got[31:0] !== 32'hC) begin bad++; $display("FAIL age_first: got %h expected %h", out_got, out_exp); end
    idle(7, 0);
    total++;
    if (out_got !== out_exp || out_got[31:0] !== 32'hD) begin bad++; $display("FAIL age_second: got %h expected %h", out_got, out_exp); end
  endtask

  task automatic test_backpressure();
    int k = 1;
    int j = 32'h100;
    int n0 = 0;
    for (int c = 0; c < 40 && k <= 4; c++) begin
      step(1, 1, k, 1, 2, j, 1, 2);
      total++;
      if (st_got !== st_exp) begin bad++; $display("FAIL bp_status: got %b expected %b", st_got, st_exp); end
      total++;
      if (out_got !== out_exp) begin bad++; $display("FAIL bp_out: got %h expected %h", out_got, out_exp); end
      if (out_got[37] && out_got[36:32] == 5'd1) n0++;
      if (m_acc[0]) k++;
      if (m_acc[1]) j++;
    end
    total++;
    if (k != 5) begin bad++; $display("FAIL bp_progress: got %0d accepted expected 4", k - 1); end
    for (int c = 0; c < 4; c++) begin
      idle(1, 2);
      total++;
      if (out_got !== out_exp) begin bad++; $display("FAIL bp_drain: got %h expected %h", out_got, out_exp); end
      if (out_got[37] && out_got[36:32] == 5'd1) n0++;
    end
    total++;
    if (n0 != 4) begin bad++; $display("FAIL bp_count: got %0d writes expected 4", n0); end
  endtask

  task automatic test_reg0();
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    total++;
    if (st_got !== 4'b1100) begin bad++; $display("FAIL reg0_status: got %b expected 1100", st_got); end
    for (int c = 0; c < 2; c++) begin
      idle(0, 0);
      total++;
      if (out_got[37] !== 1'b0 || st_got !== 4'b1100) begin bad++; $display("FAIL reg0_nowrite: got %h/%b expected we=0/1100", out_got, st_got); end
    end
  endtask

  task automatic test_async_reset();
    step(1, 9, 32'h99, 1, 10, 32'hAA, 9, 10);
    idle(0, 0);
    step(1, 11, 32'hBB, 1, 12, 32'hCC, 11, 12);
    #2;
    rst = 1'b0;
    #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.raddr1 = 11; bus.raddr2 = 12;
    #1;
    st_got  = {bus.req0_ready, bus.req1_ready, bus.hz1, bus.hz2};
    out_got = {bus.we, bus.waddr, bus.wdata};
    total++;
    if (out_got !== 38'd0) begin bad++; $display("FAIL arst_we: got %h expected 0", out_got); end
    total++;
    if (st_got !== 4'b1100) begin bad++; $display("FAIL arst_status: got %b expected 1100", st_got); end
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      idle(11, 12);
      total++;
      if (out_got !== 38'd0 || st_got !== 4'b1100) begin bad++; $display("FAIL arst_after: got %h/%b expected 0/1100", out_got, st_got); end
    end
  endtask

  task automatic test_random();
    logic v0 = 0, v1 = 0;
    logic [4:0] a0 = 0, a1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    int errs = 0;
    for (int c = 0; c < 300; c++) begin
      if (!(v0 && !m_acc[0]) || c == 0) begin
        v0 = ($urandom_range(0, 9) < 6); a0 = $urandom_range(0, 7); d0 = $urandom;
      end
      if (!(v1 && !m_acc[1]) || c == 0) begin
        v1 = ($urandom_range(0, 9) < 5); a1 = $urandom_range(0, 7); d1 = $urandom;
      end
      step(v0, a0, d0, v1, a1, d1, $urandom_range(0, 7), $urandom_range(0, 7));
      total++;
      if (st_got !== st_exp) begin bad++; errs++; if (errs < 10) $display("FAIL rand_status: cycle %0d got %b expected %b", c, st_got, st_exp); end
      total++;
      if (out_got !== out_exp) begin bad++; errs++; if (errs < 10) $display("FAIL rand_out: cycle %0d got %h expected %h", c, out_got, out_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_contention();
    test_age();
    test_backpressure();
    test_reg0();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: requester 0, the single-cycle EX/MEM pipeline result, and requester 1, the multicycle unit result (mult/div/load-miss). Each source has a one-entry holding buffer. The arbiter grants entries strictly in acceptance order and drives a registered write port into the register file. It also flags read addresses whose newest value is still buffered, so decode can stall on them.

## Interface
- DW, 32, data width (matches register width)
- AW, 5, register address width; register 0 is hard-wired zero
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req0_valid  in  1  requester 0 offers a write
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  DW  requester 0 write data
- req0_ready  out  1  requester 0 offer accepted this cycle when valid&ready
- req1_valid / req1_addr / req1_data / req1_ready: same as requester 0, for requester 1
- we  out  1  register file write enable, registered
- waddr  out  AW  register file write address, registered
- wdata  out  DW  register file write data, registered
- raddr1, raddr2  in  AW  decode-stage read addresses
- hz1, hz2  out  1  combinational: a buffered, not-yet-issued write targets raddr1 / raddr2

## Operation
- State:
  - buf_v[1:0], buf_addr[2], buf_data[2] (one entry per requester)
  - age bit old1: 1 when buffer 1 holds the older entry
  - round-robin bit rr: requester favoured on ties
  - output registers we / waddr / wdata
- Acceptance: reqN_ready = !buf_v[N] | grant[N]. When valid & ready, the buffer loads at the edge.
- Address 0: a request with addr == 0 is accepted normally but never loaded (buf_v stays 0). It produces no write.
- Grant, evaluated each cycle:
  - If exactly one buffer is valid, grant it.
  - If both are valid, grant the older one (old1 decides).
- Age bookkeeping:
  - If one buffer loads while the other stays valid and is not granted, the already-valid entry is older.
  - If both load on the same edge, the entry favoured by rr is older. rr then toggles.
  - If a buffer loads while the other is empty or being granted, the new entry is the only one, and old1 is don't-care.
- Issue: at the edge after a grant, we=1, waddr=buf_addr[g], wdata=buf_data[g], and buf_v[g] clears unless the same requester reloads. With no grant, we=0; waddr and wdata hold their previous values.
- Hazards:
  - hzK = (raddrK != 0) & ((buf_v[0] & buf_addr[0]==raddrK) | (buf_v[1] & buf_addr[1]==raddrK)).
  - An entry already in the output register is not a hazard, because the register file forwards same-cycle write data.
- Ordering guarantee: writes reach the register file in acceptance order. Same-edge acceptances are ordered by rr.
- Throughput: one write per cycle sustained. Each requester gets back-to-back acceptance while granted.

## Timing
- Reset (rst=0, async): buf_v=00, old1=0, rr=0 (requester 0 favoured), we=0, waddr=0, wdata=0. Also req0_ready=req1_ready=1 and hz1=hz2=0.
- Latency: offer accepted at edge E0, then we high during the cycle after edge E1 if it is the only or oldest entry. Worst case for the younger entry is +1 cycle.
- Buffer full with no grant: ready=0, and the requester must hold valid/addr/data stable.
- Granted and re-offered in the same cycle: the old entry issues and the new entry loads at the same edge, so there is no bubble.
- Reset asserted mid-operation discards buffered writes and any pending write immediately, and we drops at once. Requesters must re-offer.

## Test plan
- Reset then single write: req0 (addr 3, data 0x11111111) for 1 cycle, so ready=1. The next cycle has hz1=1 when raddr1=3. The cycle after that has we=1, waddr=3, wdata=0x11111111, and hz1=0.
- Same-edge contention: req0 (5, 0xA) and req1 (5, 0xB) accepted together out of reset. Writes come out on consecutive cycles: addr5=0xA, then addr5=0xB. A repeat pair comes out B-side first, because rr has toggled.
- Age order: req1 (7, 0xC) accepted, and req0 (7, 0xD) is offered the following cycle while buf1 still pends. The write order is 0xC then 0xD. req0_ready stays 1 throughout, because buf0 is empty.
- Back-pressure: hold req0 valid with consecutive data 1..4 while req1 is continuously valid. Every accepted value is written exactly once, in order, and ready deasserts only when the buffer is full and not granted.
- Register 0: req0 (0, 0xFFFFFFFF) accepted, then we stays 0 and hz with raddr=0 stays 0.
- Async reset mid-flight: both buffers valid, then rst low for half a cycle. we=0 immediately, no buffered write ever appears, and both readies are 1 after release.
